// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access unit: op codes, FSM states, CSR numbers.
// CSR_XCHG_EN enables the masked csrxchg write; otherwise op 10 behaves as csrrd.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_OP_RD   = 2'b00,
    CSR_OP_WR   = 2'b01,
    CSR_OP_XCHG = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StResp
  } csr_state_e;

  localparam logic [13:0] CSR_CRMD  = 14'h000;
  localparam logic [13:0] CSR_PRMD  = 14'h001;
  localparam logic [13:0] CSR_ERA   = 14'h006;
  localparam logic [13:0] CSR_SAVE0 = 14'h030;

  // Ops not listed here (including the reserved one) take the read-only path.
  function automatic logic csr_op_writes(csr_op_e op);
`ifdef CSR_XCHG_EN
    return (op == CSR_OP_WR) || (op == CSR_OP_XCHG);
`else
    return (op == CSR_OP_WR);
`endif
  endfunction

endpackage

// File: rtl/csr_wmask_merge.sv
// Write-data formation: plain value for csrwr, bitwise mask merge for csrxchg.
// The merge path exists only when CSR_XCHG_EN is defined.
module csr_wmask_merge
  import csr_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wval_i,
  input  logic [31:0] mask_i,
  input  csr_op_e     op_i,
  output logic [31:0] wdata_o
);

`ifdef CSR_XCHG_EN
  always_comb begin
    if (op_i == CSR_OP_XCHG) begin
      wdata_o = (wval_i & mask_i) | (old_i & ~mask_i);
    end else begin
      wdata_o = wval_i;
    end
  end
`else
  logic unused_merge;
  assign unused_merge = ^{old_i, mask_i, op_i};
  assign wdata_o      = wval_i;
`endif

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one CSR instruction at a time: read old value, optional write, respond.
// Build option CSR_XCHG_EN adds the csrxchg masked write (see csr_wmask_merge).
module csr_access_unit
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [13:0] req_addr,
  input  logic [31:0] req_wval,
  input  logic [31:0] req_mask,
  input  logic [4:0]  req_dest,
  input  logic        flush,
  output logic [13:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wr_en,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_dest
);

  csr_state_e  state_q, state_d;
  csr_op_e     op_q;
  logic [13:0] addr_q;
  logic [31:0] wval_q;
  logic [31:0] mask_q;
  logic [4:0]  dest_q;
  logic [31:0] old_q;
  logic [31:0] merged_wdata;
  logic        accept;

  assign req_ready = reset && (state_q == StIdle) && !flush;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      op_q    <= CSR_OP_RD;
      addr_q  <= '0;
      wval_q  <= '0;
      mask_q  <= '0;
      dest_q  <= '0;
      old_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= csr_op_e'(req_op);
        addr_q <= req_addr;
        wval_q <= req_wval;
        mask_q <= req_mask;
        dest_q <= req_dest;
      end
      if (state_q == StRead) begin
        old_q <= csr_rdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StRead;
      end
      StRead: begin
        if (flush) begin
          state_d = StIdle;
        end else if (csr_op_writes(op_q)) begin
          state_d = StWrite;
        end else begin
          state_d = StResp;
        end
      end
      StWrite: begin
        state_d = flush ? StIdle : StResp;
      end
      StResp: begin
        if (flush || resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  csr_wmask_merge u_wmask_merge (
    .old_i   (old_q),
    .wval_i  (wval_q),
    .mask_i  (mask_q),
    .op_i    (op_q),
    .wdata_o (merged_wdata)
  );

  // Write bus is held at zero outside the single strobe cycle.
  always_comb begin
    csr_wr_en = (state_q == StWrite) && !flush;
    csr_waddr = '0;
    csr_wdata = '0;
    if (csr_wr_en) begin
      csr_waddr = addr_q;
      csr_wdata = merged_wdata;
    end
  end

  assign csr_raddr  = addr_q;
  assign resp_valid = (state_q == StResp) && !flush;
  assign resp_data  = old_q;
  assign resp_dest  = dest_q;

endmodule
